mdu_iterative: RTL and testbench
================================

# mdu_iterative

Iterative multiply/divide unit for the MCU datapath, sitting directly downstream of the register file: it consumes the two read-port operands (RD1/RD2) for MULT/MULTU/DIV/DIVU/MTHI/MTLO and holds the HI/LO result registers. MFHI/MFLO read HI/LO back into the write-back path. While an operation runs it raises Busy so the hazard unit can stall any dependent MFHI/MFLO/MULT/DIV.

## Interface
- WIDTH, 32, operand and HI/LO width; the iteration count equals WIDTH.
- CLK  in  1  clock; all state updates on the rising edge.
- RESET  in  1  synchronous, active-high reset.
- Start  in  1  launch the operation selected by MDOp on SrcA/SrcB; sampled only in IDLE.
- MDOp  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- SrcA  in  WIDTH  multiplicand / dividend (RD1).
- SrcB  in  WIDTH  multiplier / divisor (RD2).
- HiWE  in  1  MTHI: HI <= SrcA; honoured only in IDLE with Start low.
- LoWE  in  1  MTLO: LO <= SrcA; same rules as HiWE.
- Flush  in  1  abort the running operation (exception/branch flush); HI/LO unchanged.
- Busy  out  1  operation in progress.
- Done  out  1  one-cycle pulse; HI/LO hold the new result in that same cycle.
- HI  out  WIDTH  high product / remainder.
- LO  out  WIDTH  low product / quotient.

## Operation
- Reset (RESET=1 at an edge, any state): state=IDLE, HI=0, LO=0, Busy=0, Done=0, iteration counter=0. RESET overrides Flush, Start, HiWE and LoWE.
- States: IDLE -> CALC -> FIX -> IDLE.
- IDLE, Start=1: latch the op, compute |SrcA| and |SrcB| (signed ops only; unsigned ops use the raw values), latch the result signs, clear the accumulators, counter=0, go to CALC.
- IDLE, Start=0: HiWE/LoWE write HI/LO from SrcA; both may be asserted in the same cycle.
- CALC: one radix-2 iteration per cycle.
  - Multiply: shift-add into a 2·WIDTH accumulator.
  - Divide: restoring shift-subtract, producing one quotient bit per cycle.
  - The counter increments each cycle; the iteration with counter=WIDTH-1 moves the block to FIX.
- FIX: apply the sign correction, write HI/LO, pulse Done, return to IDLE.
  - Signed multiply: 2·WIDTH product negated if sign(A) xor sign(B).
  - Signed divide: quotient negated if sign(A) xor sign(B); remainder takes the sign of the dividend.
- Divide by zero: LO=all ones; HI=SrcA (raw dividend), signed or unsigned. Runs the full latency with no special fast path.
- Signed overflow 0x80000000 / -1: LO=0x80000000, HI=0 (falls out of the magnitude method; no special case needed).
- Start, HiWE and LoWE are ignored while Busy=1.
- Start together with HiWE/LoWE in IDLE: Start wins and the writes are dropped.
- Flush in CALC or FIX: return to IDLE next edge; Busy=0, no Done, HI/LO keep their old values. Flush in IDLE has no effect, and the same-cycle Start is also dropped.

## Timing
- Edge E0 samples Start=1 in IDLE; Busy=1 from just after E0.
- Edges E1..E32 perform the WIDTH iterations; E32 moves the block to FIX.
- Edge E33 writes HI/LO and sets Done=1 and Busy=0.
- Result visible after E33, i.e. 34 cycles after the Start cycle. Busy is high for exactly 33 cycles.
- Done is high for exactly the one cycle after E33. A new Start may be sampled at E34, back-to-back with Done.
- HiWE/LoWE in IDLE: HI/LO updated at the same edge and visible the next cycle.
- HI, LO, Busy and Done are all registered outputs with no combinational path from inputs.

## Test plan
- Reset, then MULT SrcA=0xFFFFFFFD (-3), SrcB=7 -> Busy high 33 cycles; Done pulse with HI=0xFFFFFFFF, LO=0xFFFFFFEB.
- MULTU 0xFFFFFFFF × 0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001. Repeat with MULT on the same operands -> HI=0, LO=1.
- DIV 0xFFFFFFF9 (-7) / 2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIV 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0.
- DIVU 0x64 / 0 -> LO=0xFFFFFFFF, HI=0x64 after full latency. Assert Start again during Busy -> ignored; exactly one Done.
- MTHI 0x12345678 with HiWE and MTLO 0xCAFEF00D with LoWE in IDLE, then start a MULT and assert Flush at cycle 10 -> Busy drops next edge, no Done, HI/LO still 0x12345678/0xCAFEF00D.
- Start DIVU 10/3, assert RESET at cycle 20 -> HI=LO=0, Busy=0, Done never pulses. Then Start and HiWE in the same IDLE cycle -> HiWE dropped; result LO=3, HI=1 for a repeated DIVU 10/3.

Source files
------------

// File: rtl/mdu_iterative.sv
// Iterative radix-2 multiply/divide unit holding the HI/LO result registers.
// Signed operations work on magnitudes; the signs are corrected in one FIX cycle.
module mdu_iterative #(
  parameter int WIDTH = 32
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             Start,
  input  logic [1:0]       MDOp,
  input  logic [WIDTH-1:0] SrcA,
  input  logic [WIDTH-1:0] SrcB,
  input  logic             HiWE,
  input  logic             LoWE,
  input  logic             Flush,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } state_t;

  state_t           state, state_next;
  logic             busy_next, done_next;
  logic             start_ok, start_signed;
  logic             op_div, div_zero, neg_lo, neg_hi;
  logic [WIDTH-1:0] a_mag, b_mag, src_a_mag, src_b_mag;
  logic [CNT_W-1:0] count;

  logic [2*WIDTH-1:0] acc, mul_step, div_step, prod_fix;
  logic [WIDTH:0]     mul_sum, rem_shift, rem_diff;
  logic [WIDTH-1:0]   quo_fix, rem_fix;

  // MDOp[0] selects unsigned, MDOp[1] selects divide.
  assign start_signed = ~MDOp[0];
  assign start_ok     = (state == IDLE) && Start && !Flush;
  assign src_a_mag    = (start_signed && SrcA[WIDTH-1]) ? -SrcA : SrcA;
  assign src_b_mag    = (start_signed && SrcB[WIDTH-1]) ? -SrcB : SrcB;

  // Multiply: acc = {partial, multiplier}; add on LSB, then shift right.
  assign mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, a_mag} : '0);
  assign mul_step = {mul_sum, acc[WIDTH-1:1]};

  // Divide: acc = {remainder, dividend}; a borrow out of rem_diff means restore.
  assign rem_shift = acc[2*WIDTH-1:WIDTH-1];
  assign rem_diff  = rem_shift - {1'b0, b_mag};
  assign div_step  = rem_diff[WIDTH]
                   ? {rem_shift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0}
                   : {rem_diff[WIDTH-1:0],  acc[WIDTH-2:0], 1'b1};

  assign prod_fix = neg_lo ? -acc : acc;
  assign quo_fix  = div_zero ? '1 : (neg_lo ? -acc[WIDTH-1:0] : acc[WIDTH-1:0]);
  assign rem_fix  = neg_hi ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];

  always_comb begin
    // NOTE: every output of this block gets a default first so no path leaves it unassigned (no latch).
    state_next = state;
    busy_next  = 1'b0;
    done_next  = 1'b0;
    unique case (state)
      IDLE: begin
        if (start_ok) begin
          state_next = CALC;
          busy_next  = 1'b1;
        end
      end
      CALC: begin
        if (Flush) begin
          state_next = IDLE;
        end else begin
          busy_next = 1'b1;
          if (count == LAST) state_next = FIX;
        end
      end
      FIX: begin
        state_next = IDLE;
        done_next  = !Flush;
      end
      default: state_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state <= IDLE;
      Busy  <= 1'b0;
      Done  <= 1'b0;
    end else begin
      state <= state_next;
      Busy  <= busy_next;
      Done  <= done_next;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      HI       <= '0;
      LO       <= '0;
      acc      <= '0;
      a_mag    <= '0;
      b_mag    <= '0;
      count    <= '0;
      op_div   <= 1'b0;
      div_zero <= 1'b0;
      neg_lo   <= 1'b0;
      neg_hi   <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start_ok) begin
            a_mag    <= src_a_mag;
            b_mag    <= src_b_mag;
            op_div   <= MDOp[1];
            div_zero <= (SrcB == '0);
            neg_lo   <= start_signed & (SrcA[WIDTH-1] ^ SrcB[WIDTH-1]);
            neg_hi   <= start_signed & SrcA[WIDTH-1];
            acc      <= MDOp[1] ? {{WIDTH{1'b0}}, src_a_mag} : {{WIDTH{1'b0}}, src_b_mag};
            count    <= '0;
          end else if (!Start) begin
            if (HiWE) HI <= SrcA;
            if (LoWE) LO <= SrcA;
          end
        end
        CALC: begin
          if (!Flush) begin
            acc   <= op_div ? div_step : mul_step;
            count <= count + 1'b1;
          end
        end
        FIX: begin
          if (!Flush) begin
            if (op_div) begin
              HI <= rem_fix;
              LO <= quo_fix;
            end else begin
              HI <= prod_fix[2*WIDTH-1:WIDTH];
              LO <= prod_fix[WIDTH-1:0];
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mdu_iterative.sv
// Self-checking bench for mdu_iterative: directed corner cases plus randomized
// back-to-back operations compared against a plain-arithmetic reference model.
module tb_mdu_iterative;

  localparam int W = 32;

  logic         CLK = 1'b0;
  logic         RESET, Start, HiWE, LoWE, Flush;
  logic [1:0]   MDOp;
  logic [W-1:0] SrcA, SrcB;
  logic         Busy, Done;
  logic [W-1:0] HI, LO;

  int checks = 0;
  int errors = 0;

  mdu_iterative #(.WIDTH(W)) dut (
    .CLK(CLK), .RESET(RESET), .Start(Start), .MDOp(MDOp), .SrcA(SrcA), .SrcB(SrcB),
    .HiWE(HiWE), .LoWE(LoWE), .Flush(Flush), .Busy(Busy), .Done(Done), .HI(HI), .LO(LO)
  );

  always #5 CLK = ~CLK;

  // Returns {HI, LO} from the architectural definition of each operation.
  function automatic logic [63:0] ref_model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    longint      sa, sb;
    logic [31:0] q, m;
    logic [63:0] r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (op == 2'b00) r = 64'(sa * sb);
    else if (op == 2'b01) r = {32'b0, a} * {32'b0, b};
    else if (b == 32'd0) r = {a, 32'hFFFF_FFFF};
    else if (op == 2'b10) begin
      q = 32'(sa / sb);
      m = 32'(sa % sb);
      r = {m, q};
    end else begin
      q = a / b;
      m = a % b;
      r = {m, q};
    end
    return r;
  endfunction

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 7))
      0:       return 32'h0000_0000;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h0000_0001;
      default: return $urandom;
    endcase
  endfunction

  // Launches one operation from a negedge and returns at the negedge where Done is seen.
  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input string name, input bit with_hiwe);
    logic [63:0] exp;
    logic [31:0] hi_before;
    int cycles, busy_cnt;
    exp       = ref_model(op, a, b);
    hi_before = HI;
    MDOp = op; SrcA = a; SrcB = b; Start = 1'b1; HiWE = with_hiwe;
    @(posedge CLK);
    #1;
    Start = 1'b0; HiWE = 1'b0;
    SrcA = $urandom; SrcB = $urandom; MDOp = 2'($urandom);
    cycles = 0; busy_cnt = 0;
    while (cycles < 100) begin
      @(negedge CLK);
      cycles++;
      if (with_hiwe && cycles == 1) begin
        checks++;
        if (HI !== hi_before) begin
          errors++;
          $display("FAIL %s hiwe_dropped: HI got %h expected %h", name, HI, hi_before);
        end
      end
      if (Done) break;
      if (Busy) busy_cnt++;
    end
    checks++;
    if (Done !== 1'b1) begin
      errors++;
      $display("FAIL %s timeout: Done got %b expected 1 within 100 cycles", name, Done);
    end else begin
      checks += 5;
      if (cycles != 34) begin
        errors++;
        $display("FAIL %s latency: got %0d expected 34", name, cycles);
      end
      if (busy_cnt != 33) begin
        errors++;
        $display("FAIL %s busy_cycles: got %0d expected 33", name, busy_cnt);
      end
      if (Busy !== 1'b0) begin
        errors++;
        $display("FAIL %s busy_at_done: got %b expected 0", name, Busy);
      end
      if (HI !== exp[63:32]) begin
        errors++;
        $display("FAIL %s HI: op=%0d a=%h b=%h got %h expected %h", name, op, a, b, HI, exp[63:32]);
      end
      if (LO !== exp[31:0]) begin
        errors++;
        $display("FAIL %s LO: op=%0d a=%h b=%h got %h expected %h", name, op, a, b, LO, exp[31:0]);
      end
    end
  endtask

  task automatic write_hilo(input logic [31:0] hv, input logic [31:0] lv);
    SrcA = hv; HiWE = 1'b1;
    @(negedge CLK);
    HiWE = 1'b0; SrcA = lv; LoWE = 1'b1;
    @(negedge CLK);
    LoWE = 1'b0;
  endtask

  task automatic test_reset();
    RESET = 1'b1; Start = 1'b0; HiWE = 1'b0; LoWE = 1'b0; Flush = 1'b0;
    MDOp = 2'b00; SrcA = '0; SrcB = '0;
    @(negedge CLK); @(negedge CLK);
    RESET = 1'b0;
    SrcA = 32'hA5A5_A5A5; HiWE = 1'b1; LoWE = 1'b1;
    @(negedge CLK);
    HiWE = 1'b0; LoWE = 1'b0;
    checks += 2;
    if (HI !== 32'hA5A5_A5A5) begin errors++; $display("FAIL mthi_mtlo_same_cycle HI: got %h expected a5a5a5a5", HI); end
    if (LO !== 32'hA5A5_A5A5) begin errors++; $display("FAIL mthi_mtlo_same_cycle LO: got %h expected a5a5a5a5", LO); end
    RESET = 1'b1;
    @(negedge CLK);
    RESET = 1'b0;
    checks += 4;
    if (HI !== '0)    begin errors++; $display("FAIL reset HI: got %h expected 0", HI); end
    if (LO !== '0)    begin errors++; $display("FAIL reset LO: got %h expected 0", LO); end
    if (Busy !== 1'b0) begin errors++; $display("FAIL reset Busy: got %b expected 0", Busy); end
    if (Done !== 1'b0) begin errors++; $display("FAIL reset Done: got %b expected 0", Done); end
  endtask

  task automatic test_directed();
    run_op(2'b00, 32'hFFFF_FFFD, 32'd7, "mult_neg3x7", 1'b0);
    @(negedge CLK);
    checks++;
    if (Done !== 1'b0) begin errors++; $display("FAIL done_one_cycle: got %b expected 0", Done); end
    run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "multu_max", 1'b0);
    run_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mult_m1xm1", 1'b0);
    run_op(2'b10, 32'hFFFF_FFF9, 32'd2, "div_neg7_2", 1'b0);
    run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, "div_overflow", 1'b0);
    run_op(2'b10, 32'hFFFF_FFF9, 32'd0, "div_neg_by_zero", 1'b0);
  endtask

  task automatic test_busy_ignore();
    int done_cnt, done_at;
    logic [31:0] hi_s, lo_s;
    done_cnt = 0; done_at = 0; hi_s = '0; lo_s = '0;
    MDOp = 2'b11; SrcA = 32'h64; SrcB = 32'd0; Start = 1'b1;
    for (int c = 1; c <= 80; c++) begin
      @(negedge CLK);
      if (Done) begin done_cnt++; done_at = c; hi_s = HI; lo_s = LO; end
      Start = (c >= 4 && c <= 6);
      HiWE  = (c >= 4 && c <= 6);
      LoWE  = (c >= 10 && c <= 12);
      MDOp  = 2'b00;
      SrcA  = $urandom; SrcB = $urandom;
    end
    Start = 1'b0; HiWE = 1'b0; LoWE = 1'b0;
    checks += 4;
    if (done_cnt != 1)         begin errors++; $display("FAIL busy_ignore done_count: got %0d expected 1", done_cnt); end
    if (done_at != 34)         begin errors++; $display("FAIL busy_ignore latency: got %0d expected 34", done_at); end
    if (hi_s !== 32'h64)       begin errors++; $display("FAIL divu_by_zero HI: got %h expected 00000064", hi_s); end
    if (lo_s !== 32'hFFFF_FFFF) begin errors++; $display("FAIL divu_by_zero LO: got %h expected ffffffff", lo_s); end
  endtask

  task automatic test_flush(input int at);
    int done_cnt;
    logic busy_before, busy_after;
    done_cnt = 0; busy_before = 1'b0; busy_after = 1'b1;
    write_hilo(32'h1234_5678, 32'hCAFE_F00D);
    MDOp = 2'b00; SrcA = $urandom; SrcB = $urandom; Start = 1'b1;
    for (int c = 1; c <= 60; c++) begin
      @(negedge CLK);
      Start = 1'b0;
      if (Done) done_cnt++;
      if (c == at) begin busy_before = Busy; Flush = 1'b1; end
      if (c == at + 1) begin busy_after = Busy; Flush = 1'b0; end
    end
    checks += 5;
    if (busy_before !== 1'b1)  begin errors++; $display("FAIL flush@%0d busy_before: got %b expected 1", at, busy_before); end
    if (busy_after !== 1'b0)   begin errors++; $display("FAIL flush@%0d busy_after: got %b expected 0", at, busy_after); end
    if (done_cnt != 0)         begin errors++; $display("FAIL flush@%0d done_count: got %0d expected 0", at, done_cnt); end
    if (HI !== 32'h1234_5678)  begin errors++; $display("FAIL flush@%0d HI: got %h expected 12345678", at, HI); end
    if (LO !== 32'hCAFE_F00D)  begin errors++; $display("FAIL flush@%0d LO: got %h expected cafef00d", at, LO); end
  endtask

  task automatic test_flush_idle();
    MDOp = 2'b01; SrcA = 32'd5; SrcB = 32'd6; Start = 1'b1; Flush = 1'b1;
    @(negedge CLK);
    Start = 1'b0; Flush = 1'b0;
    checks++;
    if (Busy !== 1'b0) begin errors++; $display("FAIL flush_idle_start_dropped: Busy got %b expected 0", Busy); end
  endtask

  task automatic test_reset_mid();
    int done_cnt;
    done_cnt = 0;
    MDOp = 2'b11; SrcA = 32'd10; SrcB = 32'd3; Start = 1'b1;
    for (int c = 1; c <= 60; c++) begin
      @(negedge CLK);
      Start = 1'b0;
      if (Done) done_cnt++;
      if (c == 20) RESET = 1'b1;
      if (c == 21) begin
        RESET = 1'b0;
        checks += 3;
        if (HI !== '0)     begin errors++; $display("FAIL reset_mid HI: got %h expected 0", HI); end
        if (LO !== '0)     begin errors++; $display("FAIL reset_mid LO: got %h expected 0", LO); end
        if (Busy !== 1'b0) begin errors++; $display("FAIL reset_mid Busy: got %b expected 0", Busy); end
      end
    end
    checks++;
    if (done_cnt != 0) begin errors++; $display("FAIL reset_mid done_count: got %0d expected 0", done_cnt); end
    run_op(2'b11, 32'd10, 32'd3, "divu_10_3_with_hiwe", 1'b1);
  endtask

  task automatic test_random_back_to_back();
    for (int i = 0; i < 30; i++) begin
      run_op(2'($urandom), pick_operand(), pick_operand(), $sformatf("random%0d", i), 1'b0);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_busy_ignore();
    test_flush(10);
    test_flush(33);
    test_flush_idle();
    test_reset_mid();
    test_random_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
